// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Boot-time loader for the word-addressed instruction memory. Receives a byte
// stream (16-bit little-endian word count N, then N little-endian 32-bit
// words), writes the words to consecutive memory words from address 0, keeps
// the core stalled while loading and then hands the memory address port back
// to the fetch-stage PC.
//
// Optional feature (macro IMEM_BOOT_CHECKSUM_EN): after the data, one extra
// byte must equal the 8-bit modular sum of all data bytes; a match runs the
// core, a mismatch latches the error state.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   boot_bypass         skip loading, run preloaded memory (sampled in LEN_LO)
//   byte_valid/_data    loader byte stream; byte_ready = accept this cycle
//   fetch_addr          PC byte address, forwarded to imem_addr in RUN
//   imem_addr/_we/_wdata instruction memory port
//   cpu_stall           freezes PC and IF/ID until RUN
//   load_done           core running
//   load_err            sticky load error (length too large / bad checksum)
module imem_boot_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_bypass,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_err
);

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN_LO = 3'd0, LEN_HI = 3'd1, DATA = 3'd2, RUN = 3'd3, ERR = 3'd4, CSUM = 3'd5
  } state_t;
  localparam state_t END_STATE = CSUM;
  logic [7:0] sum_r;
`else
  typedef enum logic [2:0] {
    LEN_LO = 3'd0, LEN_HI = 3'd1, DATA = 3'd2, RUN = 3'd3, ERR = 3'd4
  } state_t;
  localparam state_t END_STATE = RUN;
`endif

  state_t            state_r;
  state_t            state_next_s;
  logic [15:0]       len_r;
  logic [1:0]        byte_cnt_r;
  logic [31:0]       wdata_r;
  logic              we_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic              xfer_s;
  logic              last_word_s;
  logic [15:0]       len_full_s;

  // Full word count as seen while the high length byte is on the bus.
  assign len_full_s  = {byte_data, len_r[7:0]};
  // True while the word being written is the final one of the load.
  assign last_word_s = (({{(17-ADDR_W){1'b0}}, word_idx_r} + 17'd1) == {1'b0, len_r});
  assign xfer_s      = byte_valid & byte_ready;
  assign imem_we     = we_r;
  assign imem_wdata  = wdata_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= LEN_LO;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LEN_LO: begin
        // Bypass wins over a byte presented in the same cycle.
        if (boot_bypass) begin
          state_next_s = RUN;
        end else if (xfer_s) begin
          state_next_s = LEN_HI;
        end else begin
          state_next_s = LEN_LO;
        end
      end
      LEN_HI: begin
        if (!xfer_s) begin
          state_next_s = LEN_HI;
        end else if (len_full_s == 16'd0) begin
          state_next_s = END_STATE;
        end else if ({1'b0, len_full_s} > 17'(DEPTH_WORDS)) begin
          state_next_s = ERR;
        end else begin
          state_next_s = DATA;
        end
      end
      DATA: begin
        if (we_r && last_word_s) begin
          state_next_s = END_STATE;
        end else begin
          state_next_s = DATA;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CSUM: begin
        if (!xfer_s) begin
          state_next_s = CSUM;
        end else if (byte_data == sum_r) begin
          state_next_s = RUN;
        end else begin
          state_next_s = ERR;
        end
      end
`endif
      RUN:     state_next_s = RUN;
      ERR:     state_next_s = ERR;
      default: state_next_s = ERR;
    endcase
  end

  // Output decode and memory address mux.
  always_comb begin
    byte_ready = 1'b0;
    cpu_stall  = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    imem_addr  = {{(30-ADDR_W){1'b0}}, word_idx_r, 2'b00};
    case (state_r)
      LEN_LO: byte_ready = ~boot_bypass;  // a bypassed byte must not be consumed
      LEN_HI: byte_ready = 1'b1;
      DATA:   byte_ready = ~we_r;          // hold the loader off during the write cycle
`ifdef IMEM_BOOT_CHECKSUM_EN
      CSUM:   byte_ready = 1'b1;
`endif
      RUN: begin
        cpu_stall = 1'b0;
        load_done = 1'b1;
        imem_addr = fetch_addr;
      end
      ERR:     load_err = 1'b1;
      default: load_err = 1'b1;
    endcase
  end

  // Length capture, word assembly, write strobe and word index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r      <= 16'd0;
      byte_cnt_r <= 2'd0;
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      word_idx_r <= {ADDR_W{1'b0}};
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_r      <= 8'd0;
`endif
    end else begin
      we_r <= 1'b0;
      case (state_r)
        LEN_LO: begin
          if (xfer_s) len_r[7:0] <= byte_data;
        end
        LEN_HI: begin
          if (xfer_s) len_r[15:8] <= byte_data;
        end
        DATA: begin
          if (we_r) begin
            // Keep the index on the last word so it never passes DEPTH_WORDS-1.
            if (!last_word_s) word_idx_r <= word_idx_r + ADDR_W'(1);
          end else if (xfer_s) begin
            // Little-endian: each new byte enters at the top and slides down.
            wdata_r    <= {byte_data, wdata_r[31:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) we_r <= 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_r      <= sum_r + byte_data;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        boot_bypass = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic [31:0] fetch_addr = 32'd0;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];   // {byte address, data} of each expected write
  logic [63:0] mon_e;

  imem_boot_ctrl dut (
    .clk(clk), .reset(reset), .boot_bypass(boot_bypass),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fetch_addr(fetch_addr), .imem_addr(imem_addr), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .cpu_stall(cpu_stall), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_addr", imem_addr, mon_e[63:32]);
        check_val("wr_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  // Sends a complete load of n words (at most two) and queues the expected writes.
  task automatic load(input int n, input logic [31:0] w0, input logic [31:0] w1, input int gap);
    logic [7:0]  sum = 8'd0;
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    send_byte(nn[7:0], gap);
    send_byte(nn[15:8], gap);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      exp_q.push_back({32'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gap);
        sum = sum + w[8*k +: 8];
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(sum, gap);
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (load_done !== 1'b1 && load_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_val("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_stall", 32'(cpu_stall), 32'd1);
    check_val("rst_done", 32'(load_done), 32'd0);
    check_val("rst_err", 32'(load_err), 32'd0);
    check_val("rst_ready", 32'(byte_ready), 32'd1);
    check_val("rst_we", 32'(imem_we), 32'd0);
    check_val("rst_wdata", imem_wdata, 32'd0);
    check_val("rst_addr", imem_addr, 32'd0);
    do_reset();

    // Two-word load, back-to-back bytes
    load(2, 32'h0000_0093, 32'h0050_0113, 0);
`ifndef IMEM_BOOT_CHECKSUM_EN
    @(negedge clk);
    check_val("t1_we_last", 32'(imem_we), 32'd1);
    check_val("t1_stall_during_we", 32'(cpu_stall), 32'd1);
    check_val("t1_ready_during_we", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check_val("t1_stall_after", 32'(cpu_stall), 32'd0);
`else
    wait_end();
`endif
    check_val("t1_done", 32'(load_done), 32'd1);
    check_val("t1_ready_run", 32'(byte_ready), 32'd0);
    fetch_addr = 32'h0000_0008;
    #1 check_val("t1_fetch_addr", imem_addr, 32'h0000_0008);
    fetch_addr = 32'h0000_0124;
    #1 check_val("t1_fetch_addr2", imem_addr, 32'h0000_0124);
    check_val("t1_sb_drain", 32'(exp_q.size()), 32'd0);

    // Bypass, with a byte presented that must be ignored
    reset = 1'b1;
    boot_bypass = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    check_val("byp_stall_pre", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    check_val("byp_done", 32'(load_done), 32'd1);
    check_val("byp_stall", 32'(cpu_stall), 32'd0);
    byte_valid = 1'b0;
    boot_bypass = 1'b0;
    repeat (3) @(negedge clk);
    check_val("byp_still_run", 32'(load_done), 32'd1);

    // Oversized length
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check_val("big_err", 32'(load_err), 32'd1);
    check_val("big_stall", 32'(cpu_stall), 32'd1);
    check_val("big_ready", 32'(byte_ready), 32'd0);
    check_val("big_done", 32'(load_done), 32'd0);

    // Gapped single-word load
    do_reset();
    load(1, 32'hFE20_9EE3, 32'd0, 3);
    wait_end();
    check_val("gap_done", 32'(load_done), 32'd1);
    check_val("gap_sb_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-load, then reload
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_stall", 32'(cpu_stall), 32'd1);
    check_val("mid_rst_we", 32'(imem_we), 32'd0);
    check_val("mid_rst_ready", 32'(byte_ready), 32'd1);
    do_reset();
    load(1, 32'h0640_0A13, 32'd0, 0);
    wait_end();
    check_val("mid_done", 32'(load_done), 32'd1);
    check_val("mid_sb_drain", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match
    do_reset();
    load(1, 32'h0000_0013, 32'd0, 0);
    wait_end();
    check_val("cs_ok_done", 32'(load_done), 32'd1);
    check_val("cs_ok_err", 32'(load_err), 32'd0);
    // Checksum mismatch
    do_reset();
    exp_q.push_back({32'd0, 32'h0000_0013});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h14, 0);
    wait_end();
    check_val("cs_bad_err", 32'(load_err), 32'd1);
    check_val("cs_bad_done", 32'(load_done), 32'd0);
    check_val("cs_sb_drain", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
